// File: rtl/dmem_arbiter_if.sv
// Purpose : bundles the two master request/response channels and the data-memory port of the arbiter.
// Latency : no logic here; the arbiter grants combinationally and responds one cycle after a grant.
// Backpr. : a master holds req (with stable we/addr/wdata) until it sees gnt in the same cycle.
// Ports   : m0_*/m1_* request, grant and response per master; mem_* toward the data memory.
//           slave modport = arbiter side; master modport = environment side (masters plus memory).
interface dmem_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic        m0_lock;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic        m1_lock;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_addr, mem_wdata, mem_write, mem_read,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : two-master data-memory arbiter (CPU = m0, DMA/debug = m1), round-robin with bounded lock bursts.
// Latency : grant and memory strobes are combinational; rvalid/rdata follow one cycle after each grant.
// Backpr. : a non-granted master simply keeps req high; a grant may be issued every cycle with no bubbles.
// Ports   : clk, rst_n (synchronous, active-low), bus (dmem_arbiter_if.slave: m0_*, m1_*, mem_*).
module dmem_arbiter #(
   parameter int MAX_LOCK = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   localparam int             CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   owner_e        owner_q, owner_d;
   logic          last_gnt_q, last_gnt_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;

   logic          m0_rvalid_q, m1_rvalid_q;
   logic [31:0]   m0_rdata_q, m1_rdata_q;

   logic          gnt0, gnt1;
   logic          hold0, hold1;

   // Grant selection and next-state.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      lock_cnt_d = lock_cnt_q;

      // The owner keeps its claim only while it still asserts both req and lock.
      hold0 = (owner_q == OWN_M0) && bus.m0_req && bus.m0_lock;
      hold1 = (owner_q == OWN_M1) && bus.m1_req && bus.m1_lock;

      if (hold0) begin
         // Once the burst budget is spent, yield one slot to a waiting m1.
         if ((lock_cnt_q < CNT_MAX) || !bus.m1_req) gnt0 = 1'b1;
         else                                        gnt1 = 1'b1;
      end else if (hold1) begin
         if ((lock_cnt_q < CNT_MAX) || !bus.m0_req) gnt1 = 1'b1;
         else                                        gnt0 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
         // Tie: favour the master that was not granted last.
         if (last_gnt_q) gnt0 = 1'b1;
         else            gnt1 = 1'b1;
      end else begin
         gnt0 = bus.m0_req;
         gnt1 = bus.m1_req;
      end

      // Reset aborts everything, including a lock in progress.
      if (!rst_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end

      if (gnt0) begin
         last_gnt_d = 1'b0;
         if (hold0) begin
            lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + 1'b1;
         end else if (bus.m0_lock) begin
            owner_d    = OWN_M0;
            lock_cnt_d = CW'(1);
         end else begin
            owner_d    = OWN_NONE;
            lock_cnt_d = '0;
         end
      end else if (gnt1) begin
         last_gnt_d = 1'b1;
         if (hold1) begin
            lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + 1'b1;
         end else if (bus.m1_lock) begin
            owner_d    = OWN_M1;
            lock_cnt_d = CW'(1);
         end else begin
            owner_d    = OWN_NONE;
            lock_cnt_d = '0;
         end
      end else begin
         // No grant means the owner (if any) stopped requesting.
         owner_d    = OWN_NONE;
         lock_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q     <= OWN_NONE;
         last_gnt_q  <= 1'b1;
         lock_cnt_q  <= '0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         owner_q     <= owner_d;
         last_gnt_q  <= last_gnt_d;
         lock_cnt_q  <= lock_cnt_d;
         m0_rvalid_q <= gnt0;
         m1_rvalid_q <= gnt1;
         // Writes complete with rvalid but leave the held read data untouched.
         if (gnt0 && !bus.m0_we) m0_rdata_q <= bus.mem_rdata;
         if (gnt1 && !bus.m1_we) m1_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.m0_rvalid = m0_rvalid_q;
   assign bus.m1_rvalid = m1_rvalid_q;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m1_rdata  = m1_rdata_q;

   assign bus.mem_addr  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : 32'h0);
   assign bus.mem_wdata = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : 32'h0);
   assign bus.mem_write = (gnt0 && bus.m0_we)  || (gnt1 && bus.m1_we);
   assign bus.mem_read  = (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);

endmodule
